sn_ring_stop: RTL and testbench

- Active, parametrised ring stop for the SN tile ring. Replaces the passive per-tile pass-through.
- Adds a registered ring hop with valid/ready flow control, tile-ID decode (unicast and broadcast), and a local capture FIFO toward the TC FSM.
- Injects DONE messages onto the ring back to the host tile when the TC reports completion.
- One instance per tile; instances are chained output-to-input around the ring.

---
 rtl/sn_ring_stop_if.sv | 18 +
 rtl/sn_ring_stop.sv | 220 ++++++++++++++++++++++
 tb/tb_sn_ring_stop.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn_ring_stop_if.sv
// sn_ring_stop_if: one ring hop's message channel (valid/ready plus message
// fields). The upstream side of a stop is the slave, the downstream side the master.
interface sn_ring_stop_if #(
  parameter int unsigned OP_WIDTH    = 3,
  parameter int unsigned TILE_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned WL_LEN_BITS = 32
);
  logic                   valid;
  logic                   ready;
  logic [OP_WIDTH-1:0]    op;
  logic [TILE_WIDTH-1:0]  tile;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [WL_LEN_BITS-1:0] len;

  modport master (output valid, op, tile, addr, len, input ready);
  modport slave  (input valid, op, tile, addr, len, output ready);
endinterface

// File: rtl/sn_ring_stop.sv
// sn_ring_stop: active SN tile-ring stop. Registered ring hop with valid/ready,
// unicast/broadcast tile decode into a local capture FIFO toward the TC, and
// DONE injection back to HOST_TILE when the TC reports completion.
// Optional build macro: SN_STATS_EN enables stat_captured / stat_stall counters.
module sn_ring_stop #(
  parameter int unsigned TILE_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned WL_LEN_BITS    = 32,
  parameter int unsigned OP_WIDTH       = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOST_TILE      = 0,
  parameter int unsigned DONE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TILE_WIDTH-1:0]     tile_id,
  sn_ring_stop_if.slave             ring_in,
  sn_ring_stop_if.master            ring_out,
  output logic                      tc_valid,
  input  logic                      tc_ready,
  output logic [OP_WIDTH-1:0]       tc_op,
  output logic [ADDR_WIDTH-1:0]     tc_addr,
  output logic [WL_LEN_BITS-1:0]    tc_len,
  input  logic                      tc_done,
  output logic [DONE_CNT_WIDTH-1:0] done_pending,
  output logic [31:0]               stat_captured,
  output logic [31:0]               stat_stall
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [OP_WIDTH-1:0]   OP_NOP  = '0;
  localparam logic [OP_WIDTH-1:0]   OP_DONE = '1;
  localparam logic [TILE_WIDTH-1:0] BCAST   = '1;
  localparam logic [TILE_WIDTH-1:0] HOST_ID = TILE_WIDTH'(HOST_TILE);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_HIT,
    CLS_BCAST,
    CLS_FWD
  } cls_e;

  // Ring stage register
  logic                   out_valid_q;
  logic [OP_WIDTH-1:0]    out_op_q;
  logic [TILE_WIDTH-1:0]  out_tile_q;
  logic [ADDR_WIDTH-1:0]  out_addr_q;
  logic [WL_LEN_BITS-1:0] out_len_q;

  // Capture FIFO
  logic [OP_WIDTH-1:0]    mem_op   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_addr [FIFO_DEPTH];
  logic [WL_LEN_BITS-1:0] mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;

  logic [DONE_CNT_WIDTH-1:0] done_cnt;

  cls_e cls;
  logic in_ready_c;
  logic stage_free;
  logic fifo_full;
  logic accept;
  logic push;
  logic pop;
  logic fwd;
  logic inject;
  logic done_inc;

  assign stage_free = !out_valid_q || ring_out.ready;
  assign fifo_full  = (fifo_cnt == FULL_CNT);

  // Classify the upstream message and derive in_ready from the resources it needs
  always_comb begin
    cls        = CLS_FWD;
    in_ready_c = 1'b0;
    if (ring_in.op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (ring_in.tile == tile_id) begin
      cls = CLS_HIT;
    end else if (ring_in.tile == BCAST) begin
      cls = CLS_BCAST;
    end
    unique case (cls)
      CLS_NOP:   in_ready_c = 1'b1;
      CLS_HIT:   in_ready_c = !fifo_full;
      CLS_BCAST: in_ready_c = !fifo_full && stage_free;
      CLS_FWD:   in_ready_c = stage_free;
      default:   in_ready_c = 1'b0;
    endcase
    // Nothing is accepted while reset is held, keeping every output at 0.
    if (rst) begin
      in_ready_c = 1'b0;
    end
  end

  assign ring_in.ready = in_ready_c;

  assign accept   = ring_in.valid && in_ready_c;
  assign push     = accept && (cls == CLS_HIT || cls == CLS_BCAST);
  assign fwd      = accept && (cls == CLS_BCAST || cls == CLS_FWD);
  assign pop      = tc_ready && (fifo_cnt != '0);
  // Through-traffic owns the stage; DONE only fills otherwise idle slots.
  assign inject   = (done_cnt != '0) && stage_free && !fwd;
  // A pulse at saturation is still absorbed if an injection frees a count.
  assign done_inc = tc_done && ((done_cnt != '1) || inject);

  // Ring output stage: load forward/broadcast or DONE, else drain when taken
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_tile_q  <= '0;
      out_addr_q  <= '0;
      out_len_q   <= '0;
    end else if (fwd) begin
      out_valid_q <= 1'b1;
      out_op_q    <= ring_in.op;
      out_tile_q  <= ring_in.tile;
      out_addr_q  <= ring_in.addr;
      out_len_q   <= ring_in.len;
    end else if (inject) begin
      out_valid_q <= 1'b1;
      out_op_q    <= OP_DONE;
      out_tile_q  <= HOST_ID;
      out_addr_q  <= '0;
      out_len_q   <= WL_LEN_BITS'(tile_id);
    end else if (ring_out.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ring_out.valid = out_valid_q;
  assign ring_out.op    = out_op_q;
  assign ring_out.tile  = out_tile_q;
  assign ring_out.addr  = out_addr_q;
  assign ring_out.len   = out_len_q;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= ring_in.op;
      mem_addr[wr_ptr] <= ring_in.addr;
      mem_len[wr_ptr]  <= ring_in.len;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Head fields are masked when empty so stale storage never reaches the TC.
  assign tc_valid = (fifo_cnt != '0);
  assign tc_op    = tc_valid ? mem_op[rd_ptr]   : '0;
  assign tc_addr  = tc_valid ? mem_addr[rd_ptr] : '0;
  assign tc_len   = tc_valid ? mem_len[rd_ptr]  : '0;

  // Pending DONE counter: saturating increment, decrement per injection
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else begin
      unique case ({done_inc, inject})
        2'b10:   done_cnt <= done_cnt + 1'b1;
        2'b01:   done_cnt <= done_cnt - 1'b1;
        default: done_cnt <= done_cnt;
      endcase
    end
  end

  assign done_pending = done_cnt;

`ifdef SN_STATS_EN
  logic [31:0] cap_q;
  logic [31:0] stall_q;

  // Capture and stall statistics, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q   <= '0;
      stall_q <= '0;
    end else begin
      if (push) begin
        cap_q <= cap_q + 1'b1;
      end
      if (ring_in.valid && !in_ready_c) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stat_captured = cap_q;
  assign stat_stall    = stall_q;
`else
  assign stat_captured = '0;
  assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_sn_ring_stop.sv
// tb_sn_ring_stop: scoreboard bench for sn_ring_stop (default parameters).
module tb_sn_ring_stop;

  logic       clk;
  logic       rst;
  logic [3:0] tile_id;
  logic       tc_valid;
  logic       tc_ready;
  logic [2:0] tc_op;
  logic [63:0] tc_addr;
  logic [31:0] tc_len;
  logic       tc_done;
  logic [7:0] done_pending;
  logic [31:0] stat_captured;
  logic [31:0] stat_stall;

  sn_ring_stop_if in_if ();
  sn_ring_stop_if out_if ();

  sn_ring_stop #(
    .TILE_WIDTH(4), .ADDR_WIDTH(64), .WL_LEN_BITS(32), .OP_WIDTH(3),
    .FIFO_DEPTH(4), .HOST_TILE(0), .DONE_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .tile_id(tile_id),
    .ring_in(in_if.slave), .ring_out(out_if.master),
    .tc_valid(tc_valid), .tc_ready(tc_ready), .tc_op(tc_op),
    .tc_addr(tc_addr), .tc_len(tc_len), .tc_done(tc_done),
    .done_pending(done_pending),
    .stat_captured(stat_captured), .stat_stall(stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cap  = 0;
  int exp_stall = 0;
  logic [3:0] tid;

  logic [102:0] ring_q[$];
  logic [98:0]  tc_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] t,
                      input logic [63:0] a, input logic [31:0] l);
    in_if.valid = 1'b1;
    in_if.op    = op;
    in_if.tile  = t;
    in_if.addr  = a;
    in_if.len   = l;
  endtask

  task automatic idle();
    in_if.valid = 1'b0;
    in_if.op    = '0;
    in_if.tile  = '0;
    in_if.addr  = '0;
    in_if.len   = '0;
  endtask

  // Settle, model the accept, score any output handshakes, advance one cycle.
  task automatic step();
    logic [102:0] e_r;
    logic [98:0]  e_t;
    #1;
    if (rst) begin
      exp_cap   = 0;
      exp_stall = 0;
    end else begin
      if (in_if.valid && !in_if.ready) exp_stall++;
      if (in_if.valid && in_if.ready && in_if.op != 3'd0) begin
        if (in_if.tile == tid) begin
          tc_q.push_back({in_if.op, in_if.addr, in_if.len});
          exp_cap++;
        end else if (in_if.tile == 4'hF) begin
          tc_q.push_back({in_if.op, in_if.addr, in_if.len});
          ring_q.push_back({in_if.op, in_if.tile, in_if.addr, in_if.len});
          exp_cap++;
        end else begin
          ring_q.push_back({in_if.op, in_if.tile, in_if.addr, in_if.len});
        end
      end
      if (out_if.valid && out_if.ready) begin
        if (ring_q.size() != 0) e_r = ring_q.pop_front();
        else e_r = 'x;
        check("ring_msg", {out_if.op, out_if.tile, out_if.addr, out_if.len}, e_r);
      end
      if (tc_valid && tc_ready) begin
        if (tc_q.size() != 0) e_t = tc_q.pop_front();
        else e_t = 'x;
        check("tc_msg", {tc_op, tc_addr, tc_len}, e_t);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
`ifdef SN_STATS_EN
    check({tag, "_cap"}, stat_captured, 32'(exp_cap));
    check({tag, "_stall"}, stat_stall, 32'(exp_stall));
`else
    check({tag, "_cap_off"}, stat_captured, 0);
    check({tag, "_stall_off"}, stat_stall, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    tid = 4'd3;
    tile_id = tid;
    tc_ready = 1'b0;
    tc_done = 1'b0;
    out_if.ready = 1'b0;
    idle();
    @(negedge clk);
    repeat (3) step();
    check("rst_in_ready", in_if.ready, 0);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_msg", {out_if.op, out_if.tile, out_if.addr, out_if.len}, 0);
    check("rst_tc", {tc_valid, tc_op, tc_addr, tc_len}, 0);
    check("rst_done", done_pending, 0);
    rst = 1'b0;
    step();

    // Unicast hit
    out_if.ready = 1'b1;
    send(3'd1, 4'd3, 64'h100, 32'd16);
    #1 check("uni_ready", in_if.ready, 1);
    check("uni_tc_pre", tc_valid, 0);
    step();
    idle();
    check("uni_tc_valid", tc_valid, 1);
    check("uni_tc_fields", {tc_op, tc_addr, tc_len}, {3'd1, 64'h100, 32'd16});
    check("uni_no_fwd", out_if.valid, 0);
    tc_ready = 1'b1;
    step();
    tc_ready = 1'b0;
    check("uni_popped", tc_valid, 0);

    // Forward with one-cycle latency
    send(3'd2, 4'd5, 64'h2000, 32'd8);
    step();
    idle();
    check("fwd_valid", out_if.valid, 1);
    check("fwd_no_tc", tc_valid, 0);
    step();
    check("fwd_drained", out_if.valid, 0);

    // Stage hold under backpressure, then back-to-back release
    out_if.ready = 1'b0;
    send(3'd2, 4'd6, 64'hABC, 32'd1);
    step();
    send(3'd4, 4'd7, 64'hDEF, 32'd2);
    #1 check("hold_in_ready", in_if.ready, 0);
    step();
    step();
    check("hold_stable", {out_if.valid, out_if.op, out_if.tile, out_if.addr, out_if.len},
          {1'b1, 3'd2, 4'd6, 64'hABC, 32'd1});
    out_if.ready = 1'b1;
    step();
    idle();
    step();
    check("hold_done", out_if.valid, 0);

    // Broadcast: captured and forwarded
    send(3'd3, 4'hF, 64'h300, 32'd4);
    step();
    idle();
    check("bc_both", {tc_valid, out_if.valid}, 2'b11);
    tc_ready = 1'b1;
    step();
    tc_ready = 1'b0;

    // Fill FIFO (pointers wrap), broadcast and 5th unicast must stall
    for (int i = 0; i < 4; i++) begin
      send(3'd5, 4'd3, 64'h500 + 64'(i), 32'(i));
      step();
    end
    send(3'd3, 4'hF, 64'h999, 32'd9);
    #1 check("bc_full_ready", in_if.ready, 0);
    step();
    step();
    check("bc_full_no_fwd", out_if.valid, 0);
    send(3'd5, 4'd3, 64'h777, 32'd7);
    #1 check("uni_full_ready", in_if.ready, 0);
    idle();
    check_stats("stats_a");

    // Pop one, then simultaneous push+pop keeps occupancy at 3
    tc_ready = 1'b1;
    step();
    send(3'd6, 4'd3, 64'h504, 32'd4);
    step();
    tc_ready = 1'b0;
    send(3'd6, 4'd3, 64'h505, 32'd5);
    #1 check("pushpop_ready", in_if.ready, 1);
    step();
    send(3'd6, 4'd3, 64'h506, 32'd6);
    #1 check("refull_ready", in_if.ready, 0);
    step();
    idle();
    tc_ready = 1'b1;
    repeat (4) step();
    tc_ready = 1'b0;
    check("drain_empty", tc_valid, 0);
    check("drain_q", tc_q.size(), 0);

    // Done injection deferred behind through-traffic
    rst = 1'b1;
    tid = 4'd2;
    tile_id = tid;
    ring_q.delete();
    tc_q.delete();
    step();
    rst = 1'b0;
    out_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(3'd2, 4'd5, 64'h4000 + 64'(i), 32'(i));
      tc_done = (i == 1 || i == 2 || i == 4);
      step();
    end
    tc_done = 1'b0;
    idle();
    check("done_pend3", done_pending, 3);
    for (int i = 0; i < 3; i++) ring_q.push_back({3'd7, 4'd0, 64'd0, 32'd2});
    step();
    check("done_pend2", done_pending, 2);
    step();
    check("done_pend1", done_pending, 1);
    step();
    check("done_pend0", done_pending, 0);
    step();
    step();
    check("done_all_seen", ring_q.size(), 0);
    check("done_idle", out_if.valid, 0);

    // Saturation while the stage is blocked
    out_if.ready = 1'b0;
    send(3'd2, 4'd9, 64'h88, 32'd3);
    step();
    idle();
    tc_done = 1'b1;
    repeat (260) step();
    check("done_sat", done_pending, 8'hFF);
    out_if.ready = 1'b1;
    ring_q.push_back({3'd7, 4'd0, 64'd0, 32'd2});
    step();
    tc_done = 1'b0;
    out_if.ready = 1'b0;
    check("done_coincide", done_pending, 8'hFF);
    check("done_inj_op", {out_if.valid, out_if.op, out_if.tile}, {1'b1, 3'd7, 4'd0});

    // Reset mid-operation: FIFO=2, stage full, dones pending
    send(3'd1, 4'd2, 64'h10, 32'd1);
    step();
    send(3'd1, 4'd2, 64'h20, 32'd2);
    step();
    idle();
    check("pre_rst_tc", tc_valid, 1);
    check_stats("stats_b");
    rst = 1'b1;
    ring_q.delete();
    tc_q.delete();
    step();
    check("mid_rst_out", {out_if.valid, out_if.op, out_if.tile, out_if.addr, out_if.len}, 0);
    check("mid_rst_tc", {tc_valid, tc_op, tc_addr, tc_len}, 0);
    check("mid_rst_done", done_pending, 0);
    rst = 1'b0;
    out_if.ready = 1'b1;
    tc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", {out_if.valid, tc_valid}, 0);
    end
    check_stats("stats_c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
